ube_pwrfail_seq: RTL and testbench
==================================

Name: ube_pwrfail_seq

Overview:
- Consumer side of the UBE CSR2 ACLO control bit.
- Receives the registered ACLO bit from CSR2 and drives a timed Unibus power-fail sequence: ACLO, then DCLO, then DCLO release, then ACLO release and a bus INIT pulse.
- Raises a power-fail interrupt request toward the UBE interrupt logic.
- Sits between the UBE CSR2 register and the UBE Unibus line drivers.

Parameters:
- ACLO_DLY, 16'd500, clocks ACLO is asserted before DCLO asserts; must be ≥1.
- DCLO_HOLD, 16'd100, minimum clocks DCLO is held asserted; must be ≥1.
- RECOVER_DLY, 16'd500, clocks ACLO stays asserted after DCLO releases, or after an abort; must be ≥1.
- INIT_LEN, 8'd10, INIT pulse width in clocks; must be ≥1.

Ports:
- clk  input  1  Clock.
- rst  input  1  Reset, asynchronous, active-low.
- devRESET  input  1  Device reset; synchronous, active-high.
- csr2ACLO  input  1  ACLO bit (bit 4) of UBE CSR2.
- irqACK  input  1  Interrupt acknowledge; single-cycle pulse.
- ubeACLO  output  1  Unibus ACLO line drive; active-high.
- ubeDCLO  output  1  Unibus DCLO line drive; active-high.
- ubeINIT  output  1  Unibus INIT pulse drive.
- pfIRQ  output  1  Power-fail interrupt request; level.
- pfBUSY  output  1  Sequencer not in IDLE.
- pfSTATE  output  3  Current state encoding, for debug and CSR readback.

Behaviour:
- Reset: rst low forces state IDLE, all outputs 0, timer 0, pfIRQ 0. devRESET high at a clock edge does the same synchronously, in any state.
- Single down-counter timer, 16 bits wide, loaded on every state entry with (delay − 1). The state advances in the cycle the timer reads 0. Each timed state therefore lasts exactly its parameter in clocks.
- Edge detect: start = csr2ACLO & ~aclo_q, where aclo_q is csr2ACLO registered once.
- State encodings: IDLE=0, ACLO=1, DCLO=2, RELEASE=3, RECOVER=4, INIT=5.
- IDLE: all outputs 0.
  - start → ACLO on the next edge.
  - csr2ACLO held high with no rising edge does nothing.
- ACLO: ubeACLO=1. pfIRQ is set on the entry edge.
  - If csr2ACLO=0 before the timer expires → RECOVER (abort; DCLO is never asserted).
  - Timer expires with csr2ACLO=1 → DCLO.
- DCLO: ubeACLO=1, ubeDCLO=1.
  - Leaves only when the timer has expired and csr2ACLO=0, then → RELEASE.
  - If csr2ACLO stays 1, the state holds indefinitely.
- RELEASE: ubeACLO=1, ubeDCLO=0. Lasts RECOVER_DLY, then → INIT if UBE_PWRUP_INIT_EN is defined, else → IDLE.
- RECOVER (abort path): ubeACLO=1. Lasts RECOVER_DLY, then → IDLE. No INIT pulse.
- INIT: ubeACLO=0, ubeINIT=1 for INIT_LEN clocks, then → IDLE.
- A new rising edge of csr2ACLO in any non-IDLE state is ignored. After returning to IDLE, a level still high does not restart the sequence; a fresh 0→1 transition is required.
- pfIRQ:
  - Set on entry to ACLO.
  - Cleared by irqACK, devRESET or rst.
  - If set and irqACK occur in the same cycle, set wins.
  - Otherwise pfIRQ holds across states.
- Outputs are registered and change on the clock edge that enters the state. There is no combinational path from csr2ACLO to the outputs.

Optional Feature:
- Macro UBE_PWRUP_INIT_EN.
- Defined: RELEASE → INIT, generating an INIT_LEN-clock ubeINIT pulse on power recovery.
- Undefined: RELEASE → IDLE; ubeINIT is tied to 0; the INIT state and its encoding are unused.

Test Plan:
- Full sequence, macro defined, default parameters: raise csr2ACLO at cycle 0 and drop it at cycle 800.
  - ubeACLO=1 at cycle 1; pfIRQ=1 at cycle 1.
  - ubeDCLO=1 at cycle 501, holding through cycle 800.
  - ubeDCLO=0 at cycle 802; ubeACLO=0 at cycle 1302.
  - ubeINIT=1 for cycles 1302–1311; pfBUSY=0 at cycle 1312.
- Abort: raise csr2ACLO, drop it 100 cycles later.
  - ubeDCLO never asserts.
  - ubeACLO stays asserted for 500 more cycles, then IDLE; ubeINIT stays 0.
- Minimum hold: pulse csr2ACLO high for exactly 500 cycles.
  - ubeDCLO is held for exactly DCLO_HOLD=100 cycles even though ACLO has already dropped.
- IRQ handshake:
  - Pulse irqACK in the cycle pfIRQ sets → pfIRQ stays 1.
  - Pulse irqACK one cycle later → pfIRQ=0 next cycle, and the sequence continues unaffected.
- Reset mid-operation:
  - devRESET in the DCLO state → next cycle all outputs 0, pfSTATE=0.
  - Async rst low in RELEASE → outputs 0 immediately, without a clock edge.
  - csr2ACLO held high afterward does not restart the sequence until it toggles 0→1.
- Macro undefined: repeat the full sequence → ubeINIT is never 1, and IDLE is reached at cycle 1302.

Source files
------------

// File: rtl/ube_pwrfail_seq.sv
// UBE Unibus power-fail sequencer: CSR2 ACLO bit -> timed ACLO/DCLO/INIT drive.
// Optional macro UBE_PWRUP_INIT_EN adds an INIT pulse after power recovery.
module ube_pwrfail_seq #(
    parameter logic [15:0] ACLO_DLY    = 16'd500,
    parameter logic [15:0] DCLO_HOLD   = 16'd100,
    parameter logic [15:0] RECOVER_DLY = 16'd500,
    parameter logic [7:0]  INIT_LEN    = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       devRESET,
    input  logic       csr2ACLO,
    input  logic       irqACK,
    output logic       ubeACLO,
    output logic       ubeDCLO,
    output logic       ubeINIT,
    output logic       pfIRQ,
    output logic       pfBUSY,
    output logic [2:0] pfSTATE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACLO    = 3'd1;
    localparam logic [2:0] S_DCLO    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;
    localparam logic [2:0] S_INIT    = 3'd5;

`ifdef UBE_PWRUP_INIT_EN
    localparam logic [2:0] S_REL_NEXT = S_INIT;
`else
    localparam logic [2:0] S_REL_NEXT = S_IDLE;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        aclo_q;
    logic        irq_q, irq_d;
    logic        out_aclo_q, out_aclo_d;
    logic        out_dclo_q, out_dclo_d;
    logic        busy_q, busy_d;
    logic        start;
    logic        expired;

    // Level decisions use the registered bit; only the start edge looks at the raw input.
    assign start   = csr2ACLO & ~aclo_q;
    assign expired = (timer_q == 16'd0);

    // Next-state selection for the power-fail sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_ACLO;
            S_ACLO: begin
                if (!aclo_q)      state_d = S_RECOVER;
                else if (expired) state_d = S_DCLO;
            end
            S_DCLO:    if (expired && !aclo_q) state_d = S_RELEASE;
            S_RELEASE: if (expired) state_d = S_REL_NEXT;
            S_RECOVER: if (expired) state_d = S_IDLE;
            S_INIT:    if (expired) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (devRESET) state_d = S_IDLE;
    end

    // Down-counter reloaded with (delay - 1) on every state change, parked at zero.
    always_comb begin
        timer_d = expired ? 16'd0 : (timer_q - 16'd1);
        if (state_d != state_q) begin
            unique case (state_d)
                S_ACLO:    timer_d = ACLO_DLY - 16'd1;
                S_DCLO:    timer_d = DCLO_HOLD - 16'd1;
                S_RELEASE: timer_d = RECOVER_DLY - 16'd1;
                S_RECOVER: timer_d = RECOVER_DLY - 16'd1;
                S_INIT:    timer_d = {8'd0, INIT_LEN - 8'd1};
                default:   timer_d = 16'd0;
            endcase
        end
        if (devRESET) timer_d = 16'd0;
    end

    // Interrupt request: set on ACLO entry beats a same-cycle acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (irqACK) irq_d = 1'b0;
        if (state_q == S_IDLE && state_d == S_ACLO) irq_d = 1'b1;
        if (devRESET) irq_d = 1'b0;
    end

    // Line drives decoded from the next state so they change on the entry edge.
    always_comb begin
        out_aclo_d = (state_d == S_ACLO) || (state_d == S_DCLO) ||
                     (state_d == S_RELEASE) || (state_d == S_RECOVER);
        out_dclo_d = (state_d == S_DCLO);
        busy_d     = (state_d != S_IDLE);
    end

    // Sequencer registers; the edge detector comes out of reset as 'high seen'.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            aclo_q     <= 1'b1;
            irq_q      <= 1'b0;
            out_aclo_q <= 1'b0;
            out_dclo_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            aclo_q     <= csr2ACLO;
            irq_q      <= irq_d;
            out_aclo_q <= out_aclo_d;
            out_dclo_q <= out_dclo_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UBE_PWRUP_INIT_EN
    logic init_q, init_d;

    // Bus INIT pulse after power recovery.
    always_comb begin
        init_d = (state_d == S_INIT);
    end

    // INIT drive register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) init_q <= 1'b0;
        else      init_q <= init_d;
    end

    assign ubeINIT = init_q;
`else
    assign ubeINIT = 1'b0;
`endif

    assign ubeACLO = out_aclo_q;
    assign ubeDCLO = out_dclo_q;
    assign pfIRQ   = irq_q;
    assign pfBUSY  = busy_q;
    assign pfSTATE = state_q;

endmodule

// File: tb/tb_ube_pwrfail_seq.sv
// Bench for ube_pwrfail_seq: timeline model of the power-fail sequence.
// Cycle t is the period after clock edge t; the trial's edge 0 is a devRESET edge.
module tb_ube_pwrfail_seq;

    localparam int A  = 500;
    localparam int DH = 100;
    localparam int RD = 500;
    localparam int IL = 10;
`ifdef UBE_PWRUP_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif
    localparam int FOREVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       devRESET = 1'b0;
    logic       csr2ACLO = 1'b0;
    logic       irqACK = 1'b0;
    logic       ubeACLO, ubeDCLO, ubeINIT, pfIRQ, pfBUSY;
    logic [2:0] pfSTATE;

    int tests = 0;
    int fails = 0;

    ube_pwrfail_seq dut (
        .clk(clk), .rst(rst_n), .devRESET(devRESET),
        .csr2ACLO(csr2ACLO), .irqACK(irqACK),
        .ubeACLO(ubeACLO), .ubeDCLO(ubeDCLO), .ubeINIT(ubeINIT),
        .pfIRQ(pfIRQ), .pfBUSY(pfBUSY), .pfSTATE(pfSTATE)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vec();
        return {ubeACLO, ubeDCLO, ubeINIT, pfIRQ, pfBUSY, pfSTATE};
    endfunction

    // Expected outputs at cycle t: csr high in cycles 0..h-1, ack pulse in cycle k.
    function automatic logic [7:0] model(int t, int h, int k);
        int ph;
        int l;
        logic irq;
        ph = 0;
        if (t >= 1) begin
            if (h <= A - 1) begin
                if (t <= h + 1)           ph = 1;
                else if (t <= h + 1 + RD) ph = 4;
            end else begin
                l = (A + DH > h + 1) ? A + DH : h + 1;
                if (t <= A)                         ph = 1;
                else if (t <= l)                    ph = 2;
                else if (t <= l + RD)               ph = 3;
                else if (INIT_ON && t <= l + RD + IL) ph = 5;
            end
        end
        irq = (t >= 1) && !(k >= 1 && t >= k + 1);
        return {ph >= 1 && ph <= 4, ph == 2, ph == 5, irq, ph != 0, 3'(ph)};
    endfunction

    function automatic int trial_len(int h);
        int l;
        if (h <= A - 1) return h + 1 + RD + 3;
        l = (A + DH > h + 1) ? A + DH : h + 1;
        return l + RD + (INIT_ON ? IL : 0) + 3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // r >= 0 re-raises csr from cycle r onward (used only after an abort).
    task automatic run_trial(input int h, input int k, input int r, input int stop);
        logic [7:0] exp;
        logic [7:0] got;
        csr2ACLO = 1'b0;
        irqACK   = 1'b0;
        devRESET = 1'b1;
        @(posedge clk); #1;
        devRESET = 1'b0;
        for (int t = 0; t <= stop; t++) begin
            csr2ACLO = (t < h) || (r >= 0 && t >= r);
            irqACK   = (t == k);
            @(negedge clk);
            got = vec();
            exp = model(t, h, k);
            tests++;
            assert (got === exp) else begin
                fails++;
                $error("FAIL seq h=%0d k=%0d cyc=%0d: observed %b expected %b",
                       h, k, t, got, exp);
            end
            if (t != stop) begin
                @(posedge clk); #1;
            end
        end
        irqACK = 1'b0;
    endtask

    initial begin
        int h;
        int k;
        int r;

        #2;
        chk("por_async", vec(), 8'b0);
        #20;
        rst_n = 1'b1;

        run_trial(800, -1, -1, trial_len(800));
        run_trial(800, 0, -1, 40);
        run_trial(800, 1, -1, trial_len(800));
        run_trial(100, -1, -1, trial_len(100));
        run_trial(500, -1, -1, trial_len(500));
        run_trial(1, -1, -1, trial_len(1));
        run_trial(100, -1, 250, trial_len(100) + 20);

        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(2, 499));
            k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, h + 300));
            r = ($urandom_range(0, 1) == 0) ? -1 : h + 1 + int'($urandom_range(1, 300));
            run_trial(h, k, r, trial_len(h) + ((r >= 0) ? 10 : 0));
        end
        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(501, 1100));
            k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 900));
            run_trial(h, k, -1, trial_len(h));
        end

        run_trial(FOREVER, -1, -1, 900);
        run_trial(FOREVER, -1, -1, 550);
        @(posedge clk); #1;
        devRESET = 1'b1;
        @(negedge clk);
        chk("dclo_before_devreset", vec(), {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2});
        @(posedge clk); #1;
        devRESET = 1'b0;
        @(negedge clk);
        chk("devreset_in_dclo", vec(), 8'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("devreset_level_no_restart", vec(), 8'b0);
        end

        run_trial(800, -1, -1, 900);
        csr2ACLO = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_release", vec(), 8'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_level_no_restart", vec(), 8'b0);
        end
        @(posedge clk); #1;
        csr2ACLO = 1'b0;
        @(posedge clk); #1;
        csr2ACLO = 1'b1;
        @(negedge clk);
        chk("rearm_idle", vec(), 8'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rearm_start", vec(), {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
